// File: rtl/planta_engarrafamento.sv
// Behavioural model of the bottling line plant: turns motor/valve/sealer commands
// into station sensor signals, counts finished/discarded bottles and flags illegal actuation.
module planta_engarrafamento #(
    parameter int T_TRAVEL = 8,
    parameter int T_FILL   = 12,
    parameter int T_SEAL   = 4,
    parameter int T_EXIT   = 3,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             M,
    input  logic             EV,
    input  logic             VE,
    output logic             PG,
    output logic             CH,
    output logic             RO,
    output logic             erro,
    output logic [CNT_W-1:0] produzidas,
    output logic [CNT_W-1:0] descartadas
);

    localparam int POS_MAX = (T_TRAVEL > T_EXIT) ? T_TRAVEL : T_EXIT;
    localparam int POS_W   = $clog2(POS_MAX + 1);
    localparam int FILL_W  = $clog2(T_FILL + 1);
    localparam int SEAL_W  = $clog2(T_SEAL + 1);

    localparam logic [1:0] TRANSPORTE  = 2'd0;
    localparam logic [1:0] POSICIONADA = 2'd1;
    localparam logic [1:0] SAINDO      = 2'd2;

    localparam logic [POS_W-1:0]  TRAVEL_LAST = POS_W'(T_TRAVEL - 1);
    localparam logic [POS_W-1:0]  TRAVEL_SAT  = POS_W'(T_TRAVEL);
    localparam logic [POS_W-1:0]  EXIT_LAST   = POS_W'(T_EXIT - 1);
    localparam logic [POS_W-1:0]  EXIT_SAT    = POS_W'(T_EXIT);
    localparam logic [FILL_W-1:0] FILL_FULL   = FILL_W'(T_FILL);
    localparam logic [SEAL_W-1:0] SEAL_DONE   = SEAL_W'(T_SEAL);

    function automatic logic [POS_W-1:0] pos_inc(input logic [POS_W-1:0] v,
                                                 input logic [POS_W-1:0] lim);
        return (v >= lim) ? lim : v + POS_W'(1);
    endfunction

    function automatic logic [FILL_W-1:0] fill_inc(input logic [FILL_W-1:0] v);
        return (v >= FILL_FULL) ? FILL_FULL : v + FILL_W'(1);
    endfunction

    function automatic logic [SEAL_W-1:0] seal_inc(input logic [SEAL_W-1:0] v);
        return (v >= SEAL_DONE) ? SEAL_DONE : v + SEAL_W'(1);
    endfunction

    logic [1:0]        state_q, state_d;
    logic [POS_W-1:0]  pos_q, pos_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [SEAL_W-1:0] seal_q, seal_d;
    logic              pg_q, pg_d;
    logic              ch_q, ch_d;
    logic              ro_q, ro_d;
    logic              erro_q, erro_d;
    logic [CNT_W-1:0]  produzidas_q, produzidas_d;
    logic [CNT_W-1:0]  descartadas_q, descartadas_d;
    logic              illegal_s;
    logic [POS_W-1:0]  pos_nx_s;

    // Actuation combinations that a correct controller must never issue.
    always_comb begin
        illegal_s = (EV & VE)
                  | (EV & ~pg_q)
                  | (EV & ch_q)
                  | (VE & ~ch_q)
                  | (M & (EV | VE));
    end

    // Plant state machine: conveyor position, fill/seal progress and bottle accounting.
    always_comb begin
        state_d       = state_q;
        pos_d         = pos_q;
        fill_d        = fill_q;
        seal_d        = seal_q;
        pg_d          = pg_q;
        ch_d          = ch_q;
        ro_d          = ro_q;
        erro_d        = erro_q | illegal_s;
        produzidas_d  = produzidas_q;
        descartadas_d = descartadas_q;
        pos_nx_s      = pos_inc(pos_q, EXIT_SAT);

        case (state_q)
            TRANSPORTE: begin
                pg_d = 1'b0;
                ch_d = 1'b0;
                ro_d = 1'b0;
                if (M) begin
                    if (pos_q == TRAVEL_LAST) begin
                        state_d = POSICIONADA;
                        pos_d   = '0;
                        fill_d  = '0;
                        seal_d  = '0;
                        pg_d    = 1'b1;
                    end else begin
                        pos_d = pos_inc(pos_q, TRAVEL_SAT);
                    end
                end else begin
                    pos_d = pos_q;
                end
            end

            POSICIONADA: begin
                pg_d = 1'b1;
                // Motor wins over the valve and the sealer on the same edge.
                if (M) begin
                    state_d = SAINDO;
                    pos_d   = '0;
                end else begin
                    if (EV && !VE) begin
                        fill_d = fill_inc(fill_q);
                    end else begin
                        fill_d = fill_q;
                    end
                    if (VE && !EV && ch_q) begin
                        seal_d = seal_inc(seal_q);
                    end else begin
                        seal_d = seal_q;
                    end
                end
                ch_d = (fill_d == FILL_FULL);
                ro_d = (seal_d == SEAL_DONE);
            end

            SAINDO: begin
                pg_d = 1'b1;
                // The departure edge from the station is the first exit tick.
                if (M) begin
                    if (pos_nx_s >= EXIT_LAST) begin
                        state_d = TRANSPORTE;
                        pos_d   = '0;
                        pg_d    = 1'b0;
                        ch_d    = 1'b0;
                        ro_d    = 1'b0;
                        if (ro_q) begin
                            produzidas_d = produzidas_q + CNT_W'(1);
                        end else begin
                            descartadas_d = descartadas_q + CNT_W'(1);
                        end
                    end else begin
                        pos_d = pos_nx_s;
                    end
                end else begin
                    pos_d = pos_q;
                end
            end

            default: begin
                state_d = TRANSPORTE;
                pos_d   = '0;
                fill_d  = '0;
                seal_d  = '0;
                pg_d    = 1'b0;
                ch_d    = 1'b0;
                ro_d    = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= TRANSPORTE;
            pos_q         <= '0;
            fill_q        <= '0;
            seal_q        <= '0;
            pg_q          <= 1'b0;
            ch_q          <= 1'b0;
            ro_q          <= 1'b0;
            erro_q        <= 1'b0;
            produzidas_q  <= '0;
            descartadas_q <= '0;
        end else begin
            state_q       <= state_d;
            pos_q         <= pos_d;
            fill_q        <= fill_d;
            seal_q        <= seal_d;
            pg_q          <= pg_d;
            ch_q          <= ch_d;
            ro_q          <= ro_d;
            erro_q        <= erro_d;
            produzidas_q  <= produzidas_d;
            descartadas_q <= descartadas_d;
        end
    end

    assign PG          = pg_q;
    assign CH          = ch_q;
    assign RO          = ro_q;
    assign erro        = erro_q;
    assign produzidas  = produzidas_q;
    assign descartadas = descartadas_q;

endmodule
